hilo_unit: RTL

HI/LO register file with an attached multi-cycle divider. It sits at the consuming end of the writeback-stage HI/LO pipeline register. It latches the HI/LO write that register presents and serves HI/LO reads to decode/execute (mfhi/mflo). It also runs 32-iteration signed/unsigned division for div/divu, returning quotient and remainder to execute, which routes them back through the pipeline as an ordinary HI/LO write.

---
 rtl/hilo_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// HI/LO register file with a 32-iteration restoring signed/unsigned divider.
// Define HILO_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wen,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        div_cancel,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] pr_q, pr_d;
  logic [31:0] dvs_q;
  logic        qneg_q, rneg_q;
  logic        busy_q, done_q;
  logic [31:0] quot_q, rem_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] mag_a, mag_b;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    mag_a = (div_signed && div_a[31]) ? -div_a : div_a;
    mag_b = (div_signed && div_b[31]) ? -div_b : div_b;
  end

  // Partial remainder high half is always < divisor, so the shifted-out bit
  // only needs one extra compare bit and the difference fits back in 32.
  always_comb begin
    shifted = {pr_q, 1'b0};
    trial   = shifted[64:32] - {1'b0, dvs_q};
    if (!trial[32]) begin
      pr_d = {trial[31:0], shifted[31:1], 1'b1};
    end else begin
      pr_d = shifted[63:0];
    end
    quot_fix = qneg_q ? -pr_d[31:0]  : pr_d[31:0];
    rem_fix  = rneg_q ? -pr_d[63:32] : pr_d[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_wen) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (div_cancel) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (div_start) begin
            busy_q <= 1'b1;
            if (div_b == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= div_a;
            end else begin
              state_q <= RUN;
              cnt_q   <= '0;
              pr_q    <= {32'h0, mag_a};
              dvs_q   <= mag_b;
              qneg_q  <= div_signed & (div_a[31] ^ div_b[31]);
              rneg_q  <= div_signed & div_a[31];
            end
          end
        end
        RUN: begin
          pr_q  <= pr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= quot_fix;
            rem_q   <= rem_fix;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    hi_rdata = wb_wen ? wb_hi : hi_q;
    lo_rdata = wb_wen ? wb_lo : lo_q;
  end
`else
  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
  end
`endif

  assign div_busy = busy_q;
  assign div_done = done_q;
  assign div_quot = quot_q;
  assign div_rem  = rem_q;

endmodule
